// File: rtl/btb_update_engine_pkg.sv
// Shared encodings for the BTB write-side update engine: 2-bit counter states,
// per-event action codes and the saturating counter step.
package btb_update_engine_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic [1:0] {
    ACT_UPDATE  = 2'b00,
    ACT_ALLOC   = 2'b01,
    ACT_DISCARD = 2'b10
  } btb_act_e;

  function automatic logic [1:0] sat2(input logic [1:0] state, input logic taken);
    logic [1:0] nextState;
    nextState = state;
    if (taken && state != ST) begin
      nextState = state + 2'b01;
    end else if (!taken && state != SNT) begin
      nextState = state - 2'b01;
    end
    return nextState;
  endfunction

endpackage

// File: rtl/btb_update_engine_fifo.sv
// Resolution FIFO: DEPTH entries of packed branch events, wrapping pointers and an
// occupancy count. The head is read asynchronously so a fresh push is visible next cycle.
module btb_upd_fifo #(
  parameter int W     = 68,
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               pushData,
  output logic [W-1:0]               headData,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wrPtr] <= pushData;
    end
  end

  assign headData = mem[rdPtr];

endmodule

// File: rtl/btb_update_engine.sv
// BTB update engine: queues branch resolutions, decides allocate/update/discard for the
// head event, computes the new 2-bit counter and drains one write per granted cycle.
module btb_update_engine
  import btb_update_engine_pkg::*;
#(
  parameter int         ADDR_W   = 32,
  parameter int         DEPTH    = 4,
  parameter logic [1:0] CNT_INIT = 2'b10,
  parameter int         DROP_W   = 16
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       res_valid,
  input  logic [ADDR_W-1:0]          res_pc,
  input  logic [ADDR_W-1:0]          res_target,
  input  logic                       res_taken,
  input  logic                       res_hit,
  input  logic [1:0]                 res_state,
  output logic                       res_ready,
  input  logic                       wr_grant,
  output logic                       we,
  output logic [ADDR_W-1:0]          wr_pc,
  output logic [ADDR_W-1:0]          wr_target,
  output logic [1:0]                 wr_state,
  output logic                       wr_alloc,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int EW = 2 * ADDR_W + 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic [EW-1:0]     pushData;
  logic [EW-1:0]     headData;
  logic              push;
  logic              pop;
  logic              empty;
  logic [ADDR_W-1:0] headPc;
  logic [ADDR_W-1:0] headTarget;
  logic              headTaken;
  logic              headHit;
  logic [1:0]        headState;
  btb_act_e          action;
  logic              fwd;
  logic [1:0]        baseState;
  logic              granted;

  logic              lastValid;
  logic [ADDR_W-1:0] lastPc;
  logic [1:0]        lastState;

  assign res_ready = (fifo_count != CW'(DEPTH));
  assign empty     = (fifo_count == '0);
  assign push      = res_valid && res_ready;
  assign pushData  = {res_pc, res_target, res_taken, res_hit, res_state};

  assign {headPc, headTarget, headTaken, headHit, headState} = headData;

  btb_upd_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) uFifo (
    .Clk      (Clk),
    .Rst      (Rst),
    .push     (push),
    .pop      (pop),
    .pushData (pushData),
    .headData (headData),
    .count    (fifo_count)
  );

  always_comb begin
    action    = ACT_DISCARD;
    fwd       = lastValid && (headPc == lastPc);
    baseState = fwd ? lastState : headState;
    we        = 1'b0;
    wr_pc     = '0;
    wr_target = '0;
    wr_state  = SNT;
    wr_alloc  = 1'b0;
    if (headHit) begin
      action = ACT_UPDATE;
    end else if (headTaken) begin
      action = ACT_ALLOC;
    end
    if (!empty && action != ACT_DISCARD) begin
      we        = 1'b1;
      wr_pc     = headPc;
      wr_target = headTarget;
      wr_alloc  = (action == ACT_ALLOC);
      wr_state  = (action == ACT_ALLOC) ? CNT_INIT : sat2(baseState, headTaken);
    end
  end

  assign granted = we && wr_grant;
  // Discards retire on their own; they never need the write port.
  assign pop     = granted || (!empty && action == ACT_DISCARD);

  // Remember the last committed write so a queued hit to the same PC does not
  // update from the stale counter it saw at fetch.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      lastValid <= 1'b0;
      lastPc    <= '0;
      lastState <= SNT;
    end else if (granted) begin
      lastValid <= 1'b1;
      lastPc    <= wr_pc;
      lastState <= wr_state;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      drop_cnt <= '0;
    end else if (res_valid && !res_ready && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_btb_update_engine.sv
// Directed plus randomized bench for btb_update_engine against a queue-based
// reference model of the resolution buffer and last-write forwarding.
module tb_btb_update_engine;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  logic              Clk;
  logic              Rst;
  logic              res_valid;
  logic [ADDR_W-1:0] res_pc;
  logic [ADDR_W-1:0] res_target;
  logic              res_taken;
  logic              res_hit;
  logic [1:0]        res_state;
  logic              res_ready;
  logic              wr_grant;
  logic              we;
  logic [ADDR_W-1:0] wr_pc;
  logic [ADDR_W-1:0] wr_target;
  logic [1:0]        wr_state;
  logic              wr_alloc;
  logic [2:0]        fifo_count;
  logic [15:0]       drop_cnt;

  btb_update_engine #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .CNT_INIT (2'b10),
    .DROP_W   (16)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .res_valid  (res_valid),
    .res_pc     (res_pc),
    .res_target (res_target),
    .res_taken  (res_taken),
    .res_hit    (res_hit),
    .res_state  (res_state),
    .res_ready  (res_ready),
    .wr_grant   (wr_grant),
    .we         (we),
    .wr_pc      (wr_pc),
    .wr_target  (wr_target),
    .wr_state   (wr_state),
    .wr_alloc   (wr_alloc),
    .fifo_count (fifo_count),
    .drop_cnt   (drop_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic        hit;
    logic [1:0]  st;
  } ev_t;

  ev_t         q[$];
  bit          mLastValid;
  logic [31:0] mLastPc;
  int          mLastState;
  int          mDrop;

  int vectors     = 0;
  int miscompares = 0;

  logic        seenWe;
  logic [1:0]  seenState;
  logic [31:0] seenPc;
  logic        seenReady;
  logic [2:0]  seenCount;
  logic [15:0] seenDrop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic hit, input logic [1:0] st, input logic gr);
    ev_t         h;
    ev_t         e;
    bit          expWe;
    bit          expAlloc;
    bit          disc;
    bit          readyPre;
    int          b;
    logic [1:0]  expSt;
    logic [31:0] expPc;
    logic [31:0] expTgt;
    @(negedge Clk);
    res_valid  = v;
    res_pc     = pc;
    res_target = tgt;
    res_taken  = tk;
    res_hit    = hit;
    res_state  = st;
    wr_grant   = gr;
    #1;
    expWe = 0; expAlloc = 0; disc = 0; expSt = 2'b00; expPc = '0; expTgt = '0;
    if (q.size() > 0) begin
      h = q[0];
      if (h.hit) begin
        b = (mLastValid && h.pc == mLastPc) ? mLastState : int'(h.st);
        b = h.tk ? ((b == 3) ? 3 : b + 1) : ((b == 0) ? 0 : b - 1);
        expWe = 1; expSt = b[1:0]; expPc = h.pc; expTgt = h.tgt;
      end else if (h.tk) begin
        expWe = 1; expSt = 2'b10; expAlloc = 1; expPc = h.pc; expTgt = h.tgt;
      end else begin
        disc = 1;
      end
    end
    readyPre = (q.size() != DEPTH);
    chk("res_ready",  64'(res_ready),  64'(readyPre));
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("drop_cnt",   64'(drop_cnt),   64'(mDrop));
    chk("we",         64'(we),         64'(expWe));
    chk("wr_pc",      64'(wr_pc),      64'(expPc));
    chk("wr_target",  64'(wr_target),  64'(expTgt));
    chk("wr_state",   64'(wr_state),   64'(expSt));
    chk("wr_alloc",   64'(wr_alloc),   64'(expAlloc));
    seenWe = we; seenState = wr_state; seenPc = wr_pc;
    seenReady = res_ready; seenCount = fifo_count; seenDrop = drop_cnt;
    $display("cyc t=%0t v=%0b pc=%0h gr=%0b | we=%0b wr_pc=%0h st=%0b alloc=%0b cnt=%0d drop=%0d",
             $time, v, pc, gr, we, wr_pc, wr_state, wr_alloc, fifo_count, drop_cnt);
    @(posedge Clk);
    if (expWe && gr) begin
      mLastValid = 1; mLastPc = expPc; mLastState = int'(expSt);
      void'(q.pop_front());
    end else if (disc) begin
      void'(q.pop_front());
    end
    if (v && readyPre) begin
      e.pc = pc; e.tgt = tgt; e.tk = tk; e.hit = hit; e.st = st;
      q.push_back(e);
    end else if (v) begin
      mDrop = (mDrop == 65535) ? 65535 : mDrop + 1;
    end
  endtask

  task automatic idle(input logic gr);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, gr);
  endtask

  task automatic modelReset();
    q.delete();
    mLastValid = 0; mLastPc = '0; mLastState = 0; mDrop = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rpc;
    modelReset();
    Rst = 1'b0; res_valid = 0; res_pc = '0; res_target = '0; res_taken = 0;
    res_hit = 0; res_state = 2'b00; wr_grant = 0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;

    // Reset mid-stream with three entries queued and a nonzero drop count.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h500 + i, 32'h600 + i, 1'b1, 1'b0, 2'b00, 1'b0);
    idle(1'b1);
    @(negedge Clk);
    wr_grant = 1'b1;
    #2;
    chk("pre_rst_count", 64'(fifo_count), 64'd3);
    Rst = 1'b0;
    #1;
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_we",    64'(we),         64'd0);
    chk("rst_drop",  64'(drop_cnt),   64'd0);
    chk("rst_ready", 64'(res_ready),  64'd1);
    chk("rst_wr_pc", 64'(wr_pc),      64'd0);
    $display("reset t=%0t cnt=%0d we=%0b drop=%0d", $time, fifo_count, we, drop_cnt);
    modelReset();
    @(negedge Clk);
    Rst = 1'b1;

    // Allocation from empty: write appears one cycle after the push.
    cycle(1'b1, 32'h40, 32'h80, 1'b1, 1'b0, 2'b00, 1'b1);
    chk("alloc_lat_we0", 64'(seenWe), 64'd0);
    idle(1'b1);
    chk("alloc_we",    64'(seenWe),    64'd1);
    chk("alloc_state", 64'(seenState), 64'd2);
    idle(1'b1);
    chk("alloc_popped", 64'(seenCount), 64'd0);

    // Saturation at both ends and a plain increment.
    cycle(1'b1, 32'h100, 32'h1, 1'b1, 1'b1, 2'b11, 1'b1);
    cycle(1'b1, 32'h104, 32'h2, 1'b0, 1'b1, 2'b00, 1'b1);
    chk("sat_hi", 64'(seenState), 64'd3);
    cycle(1'b1, 32'h108, 32'h3, 1'b1, 1'b1, 2'b01, 1'b1);
    chk("sat_lo", 64'(seenState), 64'd0);
    idle(1'b1);
    chk("inc_01", 64'(seenState), 64'd2);

    // Forwarding: back-to-back hits on the same pc with stale fetch counters.
    cycle(1'b1, 32'h40, 32'h80, 1'b1, 1'b1, 2'b01, 1'b1);
    cycle(1'b1, 32'h40, 32'h80, 1'b1, 1'b1, 2'b01, 1'b1);
    chk("fwd_first", 64'(seenState), 64'd2);
    idle(1'b1);
    chk("fwd_second", 64'(seenState), 64'd3);

    // Full FIFO with the port stalled, then drain in order.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h200 + i, 32'h300 + i, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("full_ready_after4", 64'(seenReady), 64'd0);
    idle(1'b0);
    chk("full_count", 64'(seenCount), 64'd4);
    chk("full_drop",  64'(seenDrop),  64'd1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("drain_order", 64'(seenPc), 64'(32'h200 + i));
    end
    idle(1'b1);

    // Discard at head concurrent with a push; forwarding state must be untouched.
    cycle(1'b1, 32'h203, 32'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    cycle(1'b1, 32'h203, 32'h999, 1'b1, 1'b1, 2'b00, 1'b1);
    chk("disc_we", 64'(seenWe), 64'd0);
    idle(1'b1);
    chk("disc_count",  64'(seenCount), 64'd1);
    chk("disc_last_fwd", 64'(seenState), 64'd3);

    // Randomized traffic on a small pc set so forwarding collisions are common.
    for (int i = 0; i < 300; i++) begin
      rpc = 32'h40 + 32'($urandom_range(0, 3)) * 4;
      cycle(1'($urandom_range(0, 99) < 60), rpc, $urandom, 1'($urandom),
            1'($urandom), 2'($urandom), 1'($urandom_range(0, 99) < 55));
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
